// File: rtl/aes_job_controller.sv
// -----------------------------------------------------------------------------
// aes_job_controller
//
// Core-clock sequencer that sits between the SPI slave's AES frame fields and
// the AES core. It takes one request at a time. A request is either a key or a
// data block.
//   - A key request loads the core key register and then waits for key
//     expansion to finish.
//   - A data request is launched on the core. The result is held for SPI
//     readout until the SPI side reports that it has been sent.
// Data is refused until a key has been loaded. Every wait on the core is
// bounded by TIMEOUT_CYCLES. Error flags are sticky.
//
// Ports
//   clk_i            core clock, rising edge
//   rst_ni           asynchronous active-low reset
//   req_valid_i      request present (already synchronised to clk_i)
//   req_data_i       key or data block
//   req_encrypt_i    1 = encrypt, 0 = decrypt (ignored for keys)
//   req_is_key_i     1 = req_data_i is a key
//   req_ready_o      request accepted when req_valid_i && req_ready_o
//   key_out_o        registered key to the core
//   key_load_o       one-cycle pulse: core samples key_out_o
//   key_ready_i      core finished key expansion
//   core_data_o      registered block to the core
//   core_encrypt_o   registered direction to the core
//   core_start_o     one-cycle pulse: core samples core_data_o/core_encrypt_o
//   core_done_i      core result valid this cycle
//   core_result_i    core output block
//   res_valid_o      result held for SPI readout
//   res_data_o       held result
//   res_encrypt_o    direction of the held result
//   res_sent_i       one-cycle pulse: result shifted out
//   key_loaded_o     a valid expanded key is present
//   err_no_key_o     sticky: data request dropped, no key loaded
//   err_timeout_o    sticky: core did not answer within TIMEOUT_CYCLES
//   busy_o           controller is not idle
// -----------------------------------------------------------------------------
module aes_job_controller #(
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_encrypt_i,
  input  logic              req_is_key_i,
  output logic              req_ready_o,
  output logic [DATA_W-1:0] key_out_o,
  output logic              key_load_o,
  input  logic              key_ready_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_encrypt_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_result_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_encrypt_o,
  input  logic              res_sent_i,
  output logic              key_loaded_o,
  output logic              err_no_key_o,
  output logic              err_timeout_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    KEY_WAIT = 2'd1,
    RUN_WAIT = 2'd2
  } state_e;

  // Value the counter holds in the last wait cycle before an abort.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   key_q;
  logic                key_load_q;
  logic [DATA_W-1:0]   core_data_q;
  logic                core_encrypt_q;
  logic                core_start_q;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                res_encrypt_q;
  logic                key_loaded_q;
  logic                err_no_key_q;
  logic                err_timeout_q;

  logic                req_ready_s;
  logic                accept_s;
  logic                at_limit_s;

  // A held result blocks new requests, and so does any wait state.
  assign req_ready_s = (state_q == IDLE) && !res_valid_q;
  assign accept_s    = req_valid_i && req_ready_s;
  assign at_limit_s  = (cnt_q == LIMIT);

  // Request sequencing, wait/timeout tracking, and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      key_q          <= '0;
      key_load_q     <= 1'b0;
      core_data_q    <= '0;
      core_encrypt_q <= 1'b0;
      core_start_q   <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_encrypt_q  <= 1'b0;
      key_loaded_q   <= 1'b0;
      err_no_key_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      key_load_q   <= 1'b0;
      core_start_q <= 1'b0;
      // A result is only ever held while IDLE, so this cannot race a capture.
      if (res_sent_i && res_valid_q) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            if (req_is_key_i) begin
              key_q         <= req_data_i;
              key_load_q    <= 1'b1;
              key_loaded_q  <= 1'b0;
              err_no_key_q  <= 1'b0;
              err_timeout_q <= 1'b0;
              cnt_q         <= '0;
              state_q       <= KEY_WAIT;
            end else if (!key_loaded_q) begin
              err_no_key_q <= 1'b1;
            end else begin
              core_data_q    <= req_data_i;
              core_encrypt_q <= req_encrypt_i;
              core_start_q   <= 1'b1;
              err_timeout_q  <= 1'b0;
              cnt_q          <= '0;
              state_q        <= RUN_WAIT;
            end
          end
        end
        KEY_WAIT: begin
          // Completion is tested first, so it wins over the timeout limit.
          if (key_ready_i) begin
            key_loaded_q <= 1'b1;
            state_q      <= IDLE;
          end else if (at_limit_s) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN_WAIT: begin
          if (core_done_i) begin
            res_data_q    <= core_result_i;
            res_encrypt_q <= core_encrypt_q;
            res_valid_q   <= 1'b1;
            state_q       <= IDLE;
          end else if (at_limit_s) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_s;
  assign key_out_o      = key_q;
  assign key_load_o     = key_load_q;
  assign core_data_o    = core_data_q;
  assign core_encrypt_o = core_encrypt_q;
  assign core_start_o   = core_start_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_encrypt_o  = res_encrypt_q;
  assign key_loaded_o   = key_loaded_q;
  assign err_no_key_o   = err_no_key_q;
  assign err_timeout_o  = err_timeout_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_controller.sv
// -----------------------------------------------------------------------------
// tb_aes_job_controller
//
// Directed and randomised stimulus for aes_job_controller. The expected values
// come from a transaction-level model of the controller, which tracks the key,
// the held result and the flags. For each wait, the model decides the outcome
// from the cycle on which the core answers:
//   - an answer on or before wait cycle 64 produces a result or a key;
//   - otherwise the wait ends at cycle 64 with a timeout.
// -----------------------------------------------------------------------------
module tb_aes_job_controller;

  localparam int W  = 128;
  localparam int TO = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic [W-1:0]  req_data_i;
  logic          req_encrypt_i;
  logic          req_is_key_i;
  logic          req_ready_o;
  logic [W-1:0]  key_out_o;
  logic          key_load_o;
  logic          key_ready_i;
  logic [W-1:0]  core_data_o;
  logic          core_encrypt_o;
  logic          core_start_o;
  logic          core_done_i;
  logic [W-1:0]  core_result_i;
  logic          res_valid_o;
  logic [W-1:0]  res_data_o;
  logic          res_encrypt_o;
  logic          res_sent_i;
  logic          key_loaded_o;
  logic          err_no_key_o;
  logic          err_timeout_o;
  logic          busy_o;

  aes_job_controller #(.DATA_W(W), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_encrypt_i(req_encrypt_i), .req_is_key_i(req_is_key_i),
    .req_ready_o(req_ready_o),
    .key_out_o(key_out_o), .key_load_o(key_load_o), .key_ready_i(key_ready_i),
    .core_data_o(core_data_o), .core_encrypt_o(core_encrypt_o),
    .core_start_o(core_start_o), .core_done_i(core_done_i),
    .core_result_i(core_result_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_encrypt_o(res_encrypt_o), .res_sent_i(res_sent_i),
    .key_loaded_o(key_loaded_o), .err_no_key_o(err_no_key_o),
    .err_timeout_o(err_timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model of everything observable while idle.
  logic         m_key_loaded, m_err_no_key, m_err_to, m_res_valid, m_res_enc, m_core_enc;
  logic [W-1:0] m_key, m_core_data, m_res_data;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_key_loaded = 1'b0; m_err_no_key = 1'b0; m_err_to = 1'b0;
    m_res_valid = 1'b0; m_res_enc = 1'b0; m_core_enc = 1'b0;
    m_key = '0; m_core_data = '0; m_res_data = '0;
  endtask

  // Compare every output against the model while the controller is idle.
  task automatic chk_all(input string tag);
    chk({tag, ".req_ready"},  req_ready_o,  !m_res_valid);
    chk({tag, ".busy"},       busy_o,       1'b0);
    chk({tag, ".key_load"},   key_load_o,   1'b0);
    chk({tag, ".core_start"}, core_start_o, 1'b0);
    chk({tag, ".key_out"},    key_out_o,    m_key);
    chk({tag, ".core_data"},  core_data_o,  m_core_data);
    chk({tag, ".core_enc"},   core_encrypt_o, m_core_enc);
    chk({tag, ".res_valid"},  res_valid_o,  m_res_valid);
    chk({tag, ".res_data"},   res_data_o,   m_res_data);
    chk({tag, ".res_enc"},    res_encrypt_o, m_res_enc);
    chk({tag, ".key_loaded"}, key_loaded_o, m_key_loaded);
    chk({tag, ".err_no_key"}, err_no_key_o, m_err_no_key);
    chk({tag, ".err_to"},     err_timeout_o, m_err_to);
  endtask

  // Present one request for a single accepting edge. The model says it must be ready.
  task automatic send_req(input logic [W-1:0] d, input logic enc, input logic is_key);
    req_valid_i = 1'b1; req_data_i = d; req_encrypt_i = enc; req_is_key_i = is_key;
    chk("req_ready_before_accept", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0; req_is_key_i = 1'b0;
  endtask

  // Key load. key_ready is high only in wait cycle kd; kd > TO means it never rises.
  task automatic do_key(input logic [W-1:0] k, input int kd);
    send_req(k, 1'b0, 1'b1);
    m_key = k; m_key_loaded = 1'b0; m_err_no_key = 1'b0; m_err_to = 1'b0;
    chk("key.load_pulse", key_load_o, 1'b1);
    chk("key.key_out", key_out_o, k);
    chk("key.busy", busy_o, 1'b1);
    chk("key.loaded_clr", key_loaded_o, 1'b0);
    chk("key.err_no_key_clr", err_no_key_o, 1'b0);
    for (int c = 1; c <= TO; c++) begin
      key_ready_i = (c == kd);
      tick();
      if (c == 1) chk("key.load_one_cycle", key_load_o, 1'b0);
      if (c == kd) m_key_loaded = 1'b1;
      else if (c == TO) m_err_to = 1'b1;
      chk("key.wait_busy", busy_o, !(c == kd || c == TO));
      chk("key.wait_err_to", err_timeout_o, m_err_to);
      if (c == kd) break;
    end
    key_ready_i = 1'b0;
    chk_all("key.done");
  endtask

  // Wait for a launched data block. core_done is high only in wait cycle dd.
  task automatic data_wait(input int dd, input logic [W-1:0] result);
    for (int c = 1; c <= TO; c++) begin
      core_done_i   = (c == dd);
      core_result_i = (c == dd) ? result : rnd128();
      tick();
      if (c == 1) chk("run.start_one_cycle", core_start_o, 1'b0);
      if (c == dd) begin
        m_res_valid = 1'b1; m_res_data = result; m_res_enc = m_core_enc;
      end else if (c == TO) begin
        m_err_to = 1'b1;
      end
      chk("run.wait_busy", busy_o, !(c == dd || c == TO));
      chk("run.wait_res_valid", res_valid_o, m_res_valid);
      chk("run.wait_err_to", err_timeout_o, m_err_to);
      if (c == dd) break;
    end
    core_done_i = 1'b0;
    chk_all("run.done");
  endtask

  // Checks right after the edge that accepted a data block with a key present.
  task automatic data_launched(input logic [W-1:0] d, input logic enc);
    m_core_data = d; m_core_enc = enc; m_err_to = 1'b0;
    chk("run.start_pulse", core_start_o, 1'b1);
    chk("run.core_data", core_data_o, d);
    chk("run.core_enc", core_encrypt_o, enc);
    chk("run.busy", busy_o, 1'b1);
    chk("run.err_to_clr", err_timeout_o, 1'b0);
  endtask

  task automatic do_data(input logic [W-1:0] d, input logic enc, input int dd,
                         input logic [W-1:0] result);
    send_req(d, enc, 1'b0);
    if (!m_key_loaded) begin
      m_err_no_key = 1'b1;
      chk_all("nokey");
    end else begin
      data_launched(d, enc);
      data_wait(dd, result);
    end
  endtask

  task automatic do_sent();
    res_sent_i = 1'b1;
    tick();
    res_sent_i = 1'b0;
    m_res_valid = 1'b0;
    chk_all("sent");
  endtask

  // Hold a new request against a held result for a few cycles, then release it.
  task automatic backpressure(input int cycles);
    req_valid_i = 1'b1; req_data_i = rnd128(); req_is_key_i = 1'($urandom_range(0, 1));
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("bp.no_start", core_start_o, 1'b0);
      chk("bp.no_keyload", key_load_o, 1'b0);
      chk("bp.ready_low", req_ready_o, 1'b0);
      chk("bp.idle", busy_o, 1'b0);
    end
    req_valid_i = 1'b0; req_is_key_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] k0, d0, r0, d1;
    k0 = 128'h000102030405060708090A0B0C0D0E0F;
    d0 = 128'hDEADBEEF_CEEDDEAD_BEEFDEAD_BEEF0000;
    r0 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;

    rst_ni = 1'b0; req_valid_i = 1'b0; req_data_i = '0; req_encrypt_i = 1'b0;
    req_is_key_i = 1'b0; key_ready_i = 1'b0; core_done_i = 1'b0;
    core_result_i = '0; res_sent_i = 1'b0;
    model_reset();
    #2;
    chk_all("reset");
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk_all("post_reset");

    // Data before any key: dropped, error flag only.
    do_data(128'hABCD_0000_1111_2222_3333_4444_5555_6666, 1'b0, 1, rnd128());
    tick(); tick();
    chk_all("nokey.stays_idle");

    // Key, key_ready three cycles after key_load; this clears err_no_key.
    do_key(k0, 4);

    // Encrypt, core_done ten cycles after core_start.
    do_data(d0, 1'b1, 11, r0);
    chk("enc.res_data", res_data_o, r0);
    chk("enc.res_enc", res_encrypt_o, 1'b1);

    // Back-pressure, then res_sent. The held request is accepted on the next edge.
    d1 = rnd128();
    req_valid_i = 1'b1; req_data_i = d1; req_encrypt_i = 1'b0; req_is_key_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp.no_start", core_start_o, 1'b0);
      chk("bp.ready_low", req_ready_o, 1'b0);
    end
    res_sent_i = 1'b1;
    tick();
    res_sent_i = 1'b0;
    m_res_valid = 1'b0;
    chk("bp.res_valid_clr", res_valid_o, 1'b0);
    chk("bp.res_data_kept", res_data_o, r0);
    chk("bp.ready_high", req_ready_o, 1'b1);
    chk("bp.no_start_yet", core_start_o, 1'b0);
    tick();
    req_valid_i = 1'b0;
    data_launched(d1, 1'b0);
    data_wait(3, rnd128());
    do_sent();

    // Timeout: core_done never arrives. Then completion in the last wait cycle.
    do_data(rnd128(), 1'b1, TO + 5, rnd128());
    chk("to.err", err_timeout_o, 1'b1);
    chk("to.no_result", res_valid_o, 1'b0);
    do_data(rnd128(), 1'b0, TO, rnd128());
    chk("to_edge.result", res_valid_o, 1'b1);
    chk("to_edge.err_clr", err_timeout_o, 1'b0);
    do_sent();

    // Key timeout: key_loaded stays 0, so the next data request is refused.
    do_key(rnd128(), TO + 1);
    do_data(rnd128(), 1'b1, 2, rnd128());
    do_key(rnd128(), TO);

    // Randomised mix of operations.
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (m_res_valid && op != 2) begin
        backpressure($urandom_range(1, 3));
        do_sent();
      end
      case (op)
        0: do_key(rnd128(), $urandom_range(0, 3) == 0 ? $urandom_range(TO - 1, TO + 4)
                                                      : $urandom_range(1, 20));
        1: begin
          do_sent();  // ignored when nothing is held
          tick();
          chk_all("rand.sent");
        end
        2: begin
          // Stray completions in IDLE are ignored.
          core_done_i = 1'b1; key_ready_i = 1'b1; core_result_i = rnd128();
          tick();
          core_done_i = 1'b0; key_ready_i = 1'b0;
          chk_all("rand.stray");
        end
        default: do_data(rnd128(), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 4) == 0 ? $urandom_range(TO - 2, TO + 3)
                                                   : $urandom_range(1, 30),
                         rnd128());
      endcase
    end
    if (m_res_valid) do_sent();

    // Reset in the middle of a data wait.
    if (!m_key_loaded) do_key(rnd128(), 2);
    d1 = rnd128();
    send_req(d1, 1'b1, 1'b0);
    data_launched(d1, 1'b1);
    for (int c = 0; c < 5; c++) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk_all("midreset");
    tick();
    rst_ni = 1'b1;
    core_done_i = 1'b1; core_result_i = rnd128();
    tick();
    core_done_i = 1'b0;
    chk_all("midreset.late_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
